// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Operand forwarding and pipeline interlock control for the ID/EX stage.
//
// Forwarding (combinational, one select per source operand):
//   fwd_sel[2i+:2] = 10 -> take EX/MEM result
//                    01 -> take MEM/WB result
//                    00 -> use register-file value
//
// Interlocks (three-state FSM: IDLE / LSTALL / MULTI):
//   - load-use hazard   : LOAD_LAT bubbles injected into ID/EX
//   - multi-cycle op    : ID/EX held for MUL_LAT-1 cycles
//   - stall_count       : saturating count of cycles with stall_if=1
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs, id_rs_used               IF/ID source registers and use flags
//   idex_rs, idex_rd                ID/EX source / destination registers
//   idex_regwrite, idex_memread     ID/EX writes a register / is a load
//   idex_multi                      ID/EX is a multi-cycle op
//   exmem_rd, exmem_regwrite        EX/MEM destination and write enable
//   memwb_rd, memwb_regwrite        MEM/WB destination and write enable
//   fwd_sel                         per-operand forwarding selects
//   stall_if, stall_id              hold PC + IF/ID, hold IF/ID contents
//   flush_idex, hold_ex             bubble into ID/EX, hold ID/EX
//   ex_busy                         FSM is not IDLE
//   stall_count                     saturating stall-cycle counter
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0]         idex_rd,
  input  logic                      idex_regwrite,
  input  logic                      idex_memread,
  input  logic                      idex_multi,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic                      exmem_regwrite,
  input  logic [REG_AW-1:0]         memwb_rd,
  input  logic                      memwb_regwrite,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      flush_idex,
  output logic                      hold_ex,
  output logic                      ex_busy,
  output logic [CNT_W-1:0]          stall_count
);

  // A single-cycle latency needs no sequencing: the IDLE-cycle action alone
  // covers it, so the FSM only leaves IDLE when there is more to do.
  localparam bit MUL_EN      = (MUL_LAT >= 2);
  localparam bit LOAD_SEQ    = (LOAD_LAT >= 2);
  localparam int MUL_INIT    = MUL_EN   ? MUL_LAT - 2  : 0;
  localparam int LOAD_INIT   = LOAD_SEQ ? LOAD_LAT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    MULTI  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_count_q;
  logic [NUM_SRC-1:0] use_match;
  logic               load_haz;

  // ---------------------------------------------------------------------------
  // Forwarding selects and per-operand load-use matches
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] ex_src;
      logic [REG_AW-1:0] id_src;
      logic              hit_exmem;
      logic              hit_memwb;

      assign ex_src    = idex_rs[gi*REG_AW +: REG_AW];
      assign id_src    = id_rs[gi*REG_AW +: REG_AW];
      // r0 is hardwired zero, so a write to it never produces a forward.
      assign hit_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_src);
      assign hit_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_src);

      // EX/MEM is the younger producer, so it wins over MEM/WB.
      assign fwd_sel[2*gi +: 2] = hit_exmem ? 2'b10 :
                                  hit_memwb ? 2'b01 : 2'b00;

      assign use_match[gi] = id_rs_used[gi] && (id_src == idex_rd);
    end
  endgenerate

  assign load_haz = idex_memread && idex_regwrite && (idex_rd != '0) && (|use_match);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Hazards are only sampled in IDLE; once a sequence has
  // started it runs to completion (or until reset).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (idex_multi && MUL_EN) begin
          state_d = MULTI;
          cnt_d   = 3'(MUL_INIT);
        end else if (load_haz && LOAD_SEQ) begin
          state_d = LSTALL;
          cnt_d   = 3'(LOAD_INIT);
        end
      end
      LSTALL: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
        end
      end
      MULTI: begin
        // cnt==0 is the op's final EX cycle: release and return to IDLE.
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Reset forces the controls low in the same cycle so an
  // in-flight sequence is aborted immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    flush_idex = 1'b0;
    hold_ex    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (idex_multi && MUL_EN) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            hold_ex  = 1'b1;
          end else if (load_haz) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            flush_idex = 1'b1;
          end
        end
        LSTALL: begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          flush_idex = 1'b1;
        end
        MULTI: begin
          if (cnt_q != 3'd0) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            hold_ex  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall_if && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Two instances share one set of inputs:
//   dut_a : LOAD_LAT=3, MUL_LAT=4 (multi-bubble / multi-hold sequences)
//   dut_b : LOAD_LAT=1, MUL_LAT=1 (single bubble, multi-cycle ops never stall)
// The reference model schedules the expected control outputs of each cycle as
// a list of future cycles, built directly from the bubble/hold counts.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NS*AW-1:0]  id_rs;
  logic [NS-1:0]     id_rs_used;
  logic [NS*AW-1:0]  idex_rs;
  logic [AW-1:0]     idex_rd;
  logic              idex_regwrite;
  logic              idex_memread;
  logic              idex_multi;
  logic [AW-1:0]     exmem_rd;
  logic              exmem_regwrite;
  logic [AW-1:0]     memwb_rd;
  logic              memwb_regwrite;

  logic [2*NS-1:0] a_fwd_sel, b_fwd_sel;
  logic a_stall_if, a_stall_id, a_flush_idex, a_hold_ex, a_ex_busy;
  logic b_stall_if, b_stall_id, b_flush_idex, b_hold_ex, b_ex_busy;
  logic [CW-1:0] a_stall_count, b_stall_count;

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(3), .MUL_LAT(4), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .idex_rs(idex_rs),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_multi(idex_multi), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .fwd_sel(a_fwd_sel),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .flush_idex(a_flush_idex),
    .hold_ex(a_hold_ex), .ex_busy(a_ex_busy), .stall_count(a_stall_count)
  );

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .LOAD_LAT(1), .MUL_LAT(1), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rs_used(id_rs_used), .idex_rs(idex_rs),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
    .idex_multi(idex_multi), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .fwd_sel(b_fwd_sel),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .flush_idex(b_flush_idex),
    .hold_ex(b_hold_ex), .ex_busy(b_ex_busy), .stall_count(b_stall_count)
  );

  // Control vector layout: {stall_if, stall_id, flush_idex, hold_ex, ex_busy}
  typedef logic [4:0] ctl_t;
  localparam ctl_t C_HOLD_FIRST = 5'b11010;
  localparam ctl_t C_HOLD_MORE  = 5'b11011;
  localparam ctl_t C_MUL_LAST   = 5'b00001;
  localparam ctl_t C_BUB_FIRST  = 5'b11100;
  localparam ctl_t C_BUB_MORE   = 5'b11101;

  ctl_t          obs_ctl [2];
  logic [CW-1:0] obs_cnt [2];
  logic [2*NS-1:0] obs_fwd [2];
  assign obs_ctl[0] = {a_stall_if, a_stall_id, a_flush_idex, a_hold_ex, a_ex_busy};
  assign obs_ctl[1] = {b_stall_if, b_stall_id, b_flush_idex, b_hold_ex, b_ex_busy};
  assign obs_cnt[0] = a_stall_count;
  assign obs_cnt[1] = b_stall_count;
  assign obs_fwd[0] = a_fwd_sel;
  assign obs_fwd[1] = b_fwd_sel;

  int checks = 0;
  int failures = 0;

  // Reference model state: a list of the control values of upcoming cycles.
  ctl_t sched [2][16];
  int   s_len [2];
  int   s_pos [2];
  ctl_t exp_ctl [2];
  int   exp_cnt [2];

  function automatic bit load_haz_ref();
    bit hit = 1'b0;
    for (int i = 0; i < NS; i++)
      if (id_rs_used[i] && (id_rs[i*AW +: AW] == idex_rd)) hit = 1'b1;
    return hit && idex_memread && idex_regwrite && (idex_rd != '0);
  endfunction

  function automatic logic [2*NS-1:0] fwd_ref();
    logic [2*NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] s = idex_rs[i*AW +: AW];
      if (exmem_regwrite && exmem_rd != 0 && exmem_rd == s)      r[2*i +: 2] = 2'b10;
      else if (memwb_regwrite && memwb_rd != 0 && memwb_rd == s) r[2*i +: 2] = 2'b01;
    end
    return r;
  endfunction

  // Expected controls for the current cycle of instance w, given the inputs.
  task automatic plan(input int w, output ctl_t c);
    int lat_l = (w == 0) ? 3 : 1;
    int lat_m = (w == 0) ? 4 : 1;
    if (reset) begin
      s_len[w] = 0; s_pos[w] = 0; c = '0;
    end else if (s_pos[w] < s_len[w]) begin
      c = sched[w][s_pos[w]];
      s_pos[w]++;
    end else begin
      s_len[w] = 0; s_pos[w] = 0;
      if (idex_multi && lat_m >= 2) begin
        // MUL_LAT-1 hold cycles in total, then one quiet final EX cycle.
        for (int k = 0; k < lat_m - 2; k++) sched[w][k] = C_HOLD_MORE;
        sched[w][lat_m-2] = C_MUL_LAST;
        s_len[w] = lat_m - 1;
        c = C_HOLD_FIRST;
      end else if (load_haz_ref()) begin
        for (int k = 0; k < lat_l - 1; k++) sched[w][k] = C_BUB_MORE;
        s_len[w] = lat_l - 1;
        c = C_BUB_FIRST;
      end else begin
        c = '0;
      end
    end
  endtask

  task automatic begin_cycle();
    plan(0, exp_ctl[0]);
    plan(1, exp_ctl[1]);
    @(negedge clk);
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      if (reset) exp_cnt[w] = 0;
      else if (exp_ctl[w][4] && exp_cnt[w] < CNT_MAX) exp_cnt[w]++;
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; id_rs = '0; id_rs_used = '0; idex_rs = '0; idex_rd = '0;
    idex_regwrite = 1'b0; idex_memread = 1'b0; idex_multi = 1'b0;
    exmem_rd = '0; exmem_regwrite = 1'b0; memwb_rd = '0; memwb_regwrite = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    begin_cycle();
    end_cycle();
    reset = 1'b0;
  endtask

  task automatic set_load_haz(input logic [1:0] used);
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 5'd7;
    id_rs = {5'd0, 5'd7}; id_rs_used = used;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      begin_cycle();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs_ctl[w][4:1] !== 4'b0000) begin
          failures++;
          $display("FAIL reset_ctl dut%0d got=%b want=0000", w, obs_ctl[w][4:1]);
        end
      end
      end_cycle();
    end
    reset = 1'b0;
    begin_cycle();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs_ctl[w] !== 5'b00000 || obs_cnt[w] !== '0) begin
        failures++;
        $display("FAIL post_reset dut%0d ctl=%b cnt=%0d want ctl=00000 cnt=0", w, obs_ctl[w], obs_cnt[w]);
      end
    end
    $display("[%0t] reset: ctl_a=%b ctl_b=%b cnt_a=%0d", $time, obs_ctl[0], obs_ctl[1], obs_cnt[0]);
    end_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_forwarding();
    logic [AW-1:0]   t_ex [5] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd0};
    logic [AW-1:0]   t_wb [5] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd9};
    logic            t_exw [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2*AW-1:0] t_rs [5] = '{{5'd5, 5'd5}, {5'd5, 5'd5}, {5'd0, 5'd0}, {5'd3, 5'd5}, {5'd9, 5'd0}};
    logic [3:0]      t_want [5] = '{4'b1010, 4'b0101, 4'b0000, 4'b0110, 4'b0100};
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      exmem_rd = t_ex[k]; memwb_rd = t_wb[k]; exmem_regwrite = t_exw[k];
      memwb_regwrite = 1'b1; idex_rs = t_rs[k];
      #1;
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs_fwd[w] !== t_want[k] || obs_fwd[w] !== fwd_ref()) begin
          failures++;
          $display("FAIL fwd_directed dut%0d case%0d got=%b want=%b", w, k, obs_fwd[w], t_want[k]);
        end
      end
      $display("[%0t] fwd case%0d: fwd_a=%b fwd_b=%b", $time, k, obs_fwd[0], obs_fwd[1]);
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    logic [4:0] pat_a = 5'b00111;  // bit k: stall_if in cycle k
    logic [4:0] pat_b = 5'b00001;
    do_reset();
    set_load_haz(2'b01);
    for (int k = 0; k < 5; k++) begin
      begin_cycle();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs_ctl[w] !== exp_ctl[w] || obs_ctl[w][4] !== ((w == 0) ? pat_a[k] : pat_b[k])) begin
          failures++;
          $display("FAIL load_use dut%0d cyc%0d got=%b want=%b", w, k, obs_ctl[w], exp_ctl[w]);
        end
      end
      if (k == 4) begin
        checks++;
        if (obs_cnt[0] !== 16'd3 || obs_cnt[1] !== 16'd1) begin
          failures++;
          $display("FAIL load_use_count got a=%0d b=%0d want a=3 b=1", obs_cnt[0], obs_cnt[1]);
        end
      end
      $display("[%0t] load_use cyc%0d: ctl_a=%b ctl_b=%b cnt_a=%0d cnt_b=%0d",
               $time, k, obs_ctl[0], obs_ctl[1], obs_cnt[0], obs_cnt[1]);
      end_cycle();
      idex_memread = 1'b0;
    end
    // Operand not actually read: no hazard.
    set_load_haz(2'b00);
    for (int k = 0; k < 2; k++) begin
      begin_cycle();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs_ctl[w] !== 5'b00000) begin
          failures++;
          $display("FAIL load_unused dut%0d cyc%0d got=%b want=00000", w, k, obs_ctl[w]);
        end
      end
      $display("[%0t] load_unused cyc%0d: ctl_a=%b ctl_b=%b", $time, k, obs_ctl[0], obs_ctl[1]);
      end_cycle();
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_multi();
    logic [4:0] hold_a = 5'b00111;
    logic [4:0] busy_a = 5'b01110;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      idex_multi = (k < 3);
      begin_cycle();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs_ctl[w] !== exp_ctl[w]) begin
          failures++;
          $display("FAIL multi dut%0d cyc%0d got=%b want=%b", w, k, obs_ctl[w], exp_ctl[w]);
        end
      end
      checks++;
      if (obs_ctl[0][1] !== hold_a[k] || obs_ctl[0][0] !== busy_a[k] || obs_ctl[1] !== 5'b00000) begin
        failures++;
        $display("FAIL multi_shape cyc%0d got a=%b b=%b want hold=%b busy=%b b=00000",
                 k, obs_ctl[0], obs_ctl[1], hold_a[k], busy_a[k]);
      end
      $display("[%0t] multi cyc%0d: ctl_a=%b ctl_b=%b", $time, k, obs_ctl[0], obs_ctl[1]);
      end_cycle();
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_multi_priority();
    do_reset();
    idex_multi = 1'b1;
    set_load_haz(2'b01);
    for (int k = 0; k < 5; k++) begin
      begin_cycle();
      for (int w = 0; w < 2; w++) begin
        checks++;
        if (obs_ctl[w] !== exp_ctl[w]) begin
          failures++;
          $display("FAIL multi_prio dut%0d cyc%0d got=%b want=%b", w, k, obs_ctl[w], exp_ctl[w]);
        end
      end
      if (k == 0) begin
        checks++;
        if (obs_ctl[0][2] !== 1'b0 || obs_ctl[0][1] !== 1'b1 || obs_ctl[1][2] !== 1'b1) begin
          failures++;
          $display("FAIL multi_prio_first got a=%b b=%b want a.flush=0 a.hold=1 b.flush=1",
                   obs_ctl[0], obs_ctl[1]);
        end
      end
      $display("[%0t] multi_prio cyc%0d: ctl_a=%b ctl_b=%b", $time, k, obs_ctl[0], obs_ctl[1]);
      end_cycle();
      idex_multi = 1'b0;
      idex_memread = 1'b0;
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_multi();
    do_reset();
    idex_multi = 1'b1;
    begin_cycle();
    end_cycle();
    reset = 1'b1;
    begin_cycle();
    checks++;
    if (obs_ctl[0][4:1] !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_multi_ctl got=%b want=0000", obs_ctl[0][4:1]);
    end
    $display("[%0t] reset_mid_multi: ctl_a=%b", $time, obs_ctl[0]);
    end_cycle();
    reset = 1'b0;
    idex_multi = 1'b0;
    begin_cycle();
    checks++;
    if (obs_ctl[0] !== 5'b00000 || obs_cnt[0] !== '0) begin
      failures++;
      $display("FAIL reset_mid_multi_after got ctl=%b cnt=%0d want ctl=00000 cnt=0", obs_ctl[0], obs_cnt[0]);
    end
    $display("[%0t] after_reset: ctl_a=%b cnt_a=%0d", $time, obs_ctl[0], obs_cnt[0]);
    end_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_saturation();
    do_reset();
    set_load_haz(2'b01);
    for (int k = 0; k < 70000; k++) begin
      begin_cycle();
      end_cycle();
    end
    begin_cycle();
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (obs_cnt[w] !== 16'hFFFF || obs_cnt[w] !== CW'(exp_cnt[w])) begin
        failures++;
        $display("FAIL saturation dut%0d got=%h want=ffff", w, obs_cnt[w]);
      end
    end
    $display("[%0t] saturation: cnt_a=%h cnt_b=%h", $time, obs_cnt[0], obs_cnt[1]);
    end_cycle();
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      reset          = ($urandom_range(0, 63) == 0);
      idex_multi     = ($urandom_range(0, 7) == 0);
      idex_memread   = ($urandom_range(0, 2) == 0);
      idex_regwrite  = $urandom_range(0, 1);
      exmem_regwrite = $urandom_range(0, 1);
      memwb_regwrite = $urandom_range(0, 1);
      idex_rd        = AW'($urandom_range(0, 3));
      exmem_rd       = AW'($urandom_range(0, 3));
      memwb_rd       = AW'($urandom_range(0, 3));
      id_rs_used     = NS'($urandom_range(0, 3));
      for (int i = 0; i < NS; i++) begin
        id_rs[i*AW +: AW]   = AW'($urandom_range(0, 3));
        idex_rs[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      begin_cycle();
      for (int w = 0; w < 2; w++) begin
        ctl_t m = reset ? 5'b11110 : 5'b11111;
        checks++;
        if ((obs_ctl[w] & m) !== (exp_ctl[w] & m) || obs_cnt[w] !== CW'(exp_cnt[w])
            || obs_fwd[w] !== fwd_ref()) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d ctl=%b/%b cnt=%0d/%0d fwd=%b/%b (got/want)",
                   w, k, obs_ctl[w], exp_ctl[w], obs_cnt[w], exp_cnt[w], obs_fwd[w], fwd_ref());
        end
      end
      $display("[%0t] random cyc%0d rst=%b: ctl_a=%b ctl_b=%b fwd=%b cnt_a=%0d cnt_b=%0d",
               $time, k, reset, obs_ctl[0], obs_ctl[1], obs_fwd[0], obs_cnt[0], obs_cnt[1]);
      end_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    s_len = '{0, 0};
    s_pos = '{0, 0};
    exp_cnt = '{0, 0};
    idle_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_multi();
    test_multi_priority();
    test_reset_mid_multi();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor to the single-cycle forwarding unit. It generates the ID/EX operand forwarding selects for NUM_SRC source operands. It also owns pipeline interlocks: a load-use bubble sequencer with configurable load latency, a multi-cycle execute hold sequencer, and a saturating stall-cycle performance counter. It sits beside the ID/EX register and drives the operand muxes plus the IF/ID and ID/EX stall/flush controls.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, number of source operands per instruction (1..4)
LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..4)
MUL_LAT, 3, EX residence in cycles of a multi-cycle op (1..8)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_rs  in  NUM_SRC*REG_AW  IF/ID source regs; operand i at [i*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  operand i actually read by the ID instruction
idex_rs  in  NUM_SRC*REG_AW  ID/EX source regs, same packing
idex_rd  in  REG_AW  ID/EX destination
idex_regwrite  in  1  ID/EX writes a register
idex_memread  in  1  ID/EX is a load
idex_multi  in  1  ID/EX is a multi-cycle op
exmem_rd  in  REG_AW  EX/MEM destination
exmem_regwrite  in  1  EX/MEM writes a register
memwb_rd  in  REG_AW  MEM/WB destination
memwb_regwrite  in  1  MEM/WB writes a register
fwd_sel  out  2*NUM_SRC  per-operand select at [2i+:2]: 00 regfile, 10 EX/MEM, 01 MEM/WB
stall_if  out  1  hold PC and IF/ID
stall_id  out  1  hold IF/ID contents
flush_idex  out  1  load bubble into ID/EX
hold_ex  out  1  hold ID/EX (multi-cycle op stays in EX)
ex_busy  out  1  FSM not IDLE
stall_count  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Forwarding is combinational and evaluated independently for each operand i:
  - If exmem_regwrite, exmem_rd!=0 and exmem_rd==idex_rs[i], select 10.
  - Else if memwb_regwrite, memwb_rd!=0 and memwb_rd==idex_rs[i], select 01.
  - Else select 00.
  - Forwarding stays active in every FSM state.
- Load hazard: load_haz = idex_memread & idex_regwrite & idex_rd!=0 & OR over i of (id_rs_used[i] & id_rs[i]==idex_rd).
- FSM states are IDLE, LSTALL and MULTI; a down-counter cnt is 3 bits wide.
- IDLE, with idex_multi=1 and MUL_LAT>=2 (priority over load_haz):
  - Assert stall_if, stall_id, hold_ex.
  - cnt<=MUL_LAT-2; next state MULTI.
- IDLE, else if load_haz:
  - Assert stall_if, stall_id, flush_idex.
  - If LOAD_LAT>=2: cnt<=LOAD_LAT-1, next state LSTALL; otherwise stay in IDLE.
- IDLE, otherwise: all control outputs are 0.
- idex_multi with MUL_LAT=1 never stalls.
- MULTI:
  - cnt!=0: assert stall_if, stall_id, hold_ex; cnt<=cnt-1.
  - cnt==0: all controls 0, next state IDLE. This is the op's final EX cycle.
  - Total hold cycles = MUL_LAT-1.
- LSTALL:
  - Assert stall_if, stall_id, flush_idex every cycle.
  - If cnt==1, next state IDLE; else cnt<=cnt-1.
  - Total bubbles = LOAD_LAT.
- The FSM does not re-evaluate hazards while in LSTALL or MULTI.
- ex_busy = (state!=IDLE).
- stall_count increments by 1 on each cycle with stall_if=1 and saturates at all-ones.
- Reset:
  - When reset=1, all control outputs are forced to 0 in that same cycle.
  - At the edge: state<=IDLE, cnt<=0, stall_count<=0.
  - Reset taken mid-LSTALL or mid-MULTI aborts immediately.
  - fwd_sel remains combinational during reset.
- flush_idex and hold_ex are never asserted in the same cycle.

Test Plan:
- Forwarding, NUM_SRC=2: exmem_rd=5, memwb_rd=5, both regwrite=1, idex_rs={5,5} -> fwd_sel=4'b1010. With exmem_regwrite=0 -> 4'b0101. With all rd=0 -> 4'b0000.
- Load-use, LOAD_LAT=1: idex_memread=1, idex_rd=7, id_rs[0]=7, used=01 -> stall_if/stall_id/flush_idex high exactly 1 cycle, ex_busy stays 0, stall_count=1. Same stimulus with used=00 -> no stall.
- Load-use, LOAD_LAT=3 -> 3 consecutive bubble cycles (IDLE, LSTALL, LSTALL), then IDLE with controls 0; stall_count=3.
- Multi, MUL_LAT=4: idex_multi=1 held while hold_ex=1 -> hold_ex high 3 cycles, 4th cycle controls 0 with state MULTI, then IDLE. With idex_memread=1 and load_haz also true in the same cycle -> multi path wins, flush_idex=0.
- Reset asserted in the 2nd MULTI cycle -> controls 0 in that cycle, state IDLE and stall_count=0 next cycle. Then drive 70000 stall cycles with CNT_W=16 -> stall_count holds at 16'hFFFF.
